// File: rtl/expr_pkg.sv
// Shared definitions for the ASCII arithmetic-expression character stream.
// Used by the transmitter (expr_string_tx) and by the recognizer side, so the
// character codes live here rather than in either endpoint.
package expr_pkg;

   // Sequencer states; ST_TERM is only reachable when EXPR_TX_TERMINATOR_EN is defined
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DIGIT = 3'd1,
      ST_OPER  = 3'd2,
      ST_FIN   = 3'd3,
      ST_TERM  = 3'd4
   } expr_state_e;

   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;

endpackage

// File: rtl/expr_req_check.sv
// Combinational validation of a transmit request: the term count must be in
// 1..MAX_TERMS and every term that will actually be sent must be a BCD digit.
// Terms beyond n_terms_i are don't-care and never inspected.
module expr_req_check #(
   parameter int MAX_TERMS = 4
) (
   input  logic [3:0]             n_terms_i,
   input  logic [4*MAX_TERMS-1:0] digits_i,
   output logic                   req_ok_o
);

   // Range check on the count, then reject any in-use term above 9
   always_comb begin
      req_ok_o = (n_terms_i != 4'd0) && (n_terms_i <= 4'(MAX_TERMS));
      for (int i = 0; i < MAX_TERMS; i++) begin
         if ((4'(i) < n_terms_i) && (digits_i[4*i +: 4] > 4'd9)) begin
            req_ok_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/expr_string_tx.sv
// Transmitter for the ASCII expression stream: digit, operator, digit, ...
// One character per valid/ready handshake; outputs are registered.
// Optional build macro EXPR_TX_TERMINATOR_EN appends an '=' character after
// the final digit, which then carries 'last' instead of the digit.
module expr_string_tx
   import expr_pkg::*;
#(
   parameter int MAX_TERMS = 4
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic                   start,
   input  logic [3:0]             n_terms,
   input  logic [4*MAX_TERMS-1:0] digits,
   input  logic [MAX_TERMS-2:0]   ops,
   output logic [7:0]             char_out,
   output logic                   char_valid,
   input  logic                   char_ready,
   output logic                   last,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   expr_state_e                state_q, state_d;
   logic [3:0]                 idx_q, idx_d;
   logic [3:0]                 nterms_q, nterms_d;
   logic [4*MAX_TERMS-1:0]     digits_q, digits_d;
   logic [MAX_TERMS-2:0]       ops_q, ops_d;
   logic [7:0]                 char_q, char_d;
   logic                       valid_q, valid_d;
   logic                       last_q, last_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic                       req_ok;

   expr_req_check #(.MAX_TERMS(MAX_TERMS)) u_req_check (
      .n_terms_i (n_terms),
      .digits_i  (digits),
      .req_ok_o  (req_ok)
   );

   function automatic logic [3:0] digitAt(input logic [4*MAX_TERMS-1:0] d, input logic [3:0] k);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < MAX_TERMS; i++) begin
         if (k == 4'(i)) r = d[4*i +: 4];
      end
      return r;
   endfunction

   function automatic logic [7:0] opChar(input logic [MAX_TERMS-2:0] o, input logic [3:0] k);
      logic [7:0] r;
      r = CH_PLUS;
      for (int i = 0; i < MAX_TERMS - 1; i++) begin
         if ((k == 4'(i)) && o[i]) r = CH_STAR;
      end
      return r;
   endfunction

   // With the terminator enabled the '=' owns 'last', so no digit ever does
   function automatic logic isLastDigit(input logic [3:0] k, input logic [3:0] n);
`ifdef EXPR_TX_TERMINATOR_EN
      return 1'b0 & (k == n);
`else
      return k == (n - 4'd1);
`endif
   endfunction

   // Next-state and next-output decode; the character for the next state is
   // computed here so that char_out/last/char_valid are pure flop outputs
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nterms_d = nterms_q;
      digits_d = digits_q;
      ops_d    = ops_q;
      char_d   = char_q;
      valid_d  = valid_q;
      last_d   = last_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            char_d  = 8'h00;
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (start) begin
               if (req_ok) begin
                  nterms_d = n_terms;
                  digits_d = digits;
                  ops_d    = ops;
                  idx_d    = 4'd0;
                  state_d  = ST_DIGIT;
                  char_d   = CH_ZERO + {4'h0, digits[3:0]};
                  valid_d  = 1'b1;
                  last_d   = isLastDigit(4'd0, n_terms);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DIGIT: begin
            if (char_ready) begin
               if (idx_q == (nterms_q - 4'd1)) begin
`ifdef EXPR_TX_TERMINATOR_EN
                  state_d = ST_TERM;
                  char_d  = CH_EQ;
                  valid_d = 1'b1;
                  last_d  = 1'b1;
`else
                  state_d = ST_FIN;
                  char_d  = 8'h00;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = ST_OPER;
                  char_d  = opChar(ops_q, idx_q);
                  last_d  = 1'b0;
               end
            end
         end
         ST_OPER: begin
            if (char_ready) begin
               idx_d   = idx_q + 4'd1;
               state_d = ST_DIGIT;
               char_d  = CH_ZERO + {4'h0, digitAt(digits_q, idx_q + 4'd1)};
               last_d  = isLastDigit(idx_q + 4'd1, nterms_q);
            end
         end
`ifdef EXPR_TX_TERMINATOR_EN
         ST_TERM: begin
            if (char_ready) begin
               state_d = ST_FIN;
               char_d  = 8'h00;
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
`endif
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            char_d  = 8'h00;
         end
      endcase
   end

   // State and output registers; reset abandons any partial expression
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= 4'd0;
         nterms_q <= 4'd0;
         digits_q <= '0;
         ops_q    <= '0;
         char_q   <= 8'h00;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nterms_q <= nterms_d;
         digits_q <= digits_d;
         ops_q    <= ops_d;
         char_q   <= char_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign char_out   = char_q;
   assign char_valid = valid_q;
   assign last       = last_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_expr_string_tx.sv
// Self-checking bench for expr_string_tx. A queue-based model expands each
// accepted request into its expected character stream; a negedge monitor
// checks every presented character, stalls, and the done pulse.
module tb_expr_string_tx;

   localparam int MT = 4;

   logic              clk = 1'b0;
   logic              clr_n = 1'b0;
   logic              start = 1'b0;
   logic [3:0]        n_terms = 4'd0;
   logic [4*MT-1:0]   digits = '0;
   logic [MT-2:0]     ops = '0;
   logic              char_ready = 1'b0;
   logic [7:0]        char_out;
   logic              char_valid, last, busy, done, err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pops = 0;
   int first_cyc = 0;
   int done_cyc = 0;
   int ready_mode = 0;

   logic [8:0] expq[$];
   logic [7:0] seen[$];
   bit         done_due = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_char = 8'h00;
   logic       prev_last = 1'b0;

   expr_string_tx #(.MAX_TERMS(MT)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .start      (start),
      .n_terms    (n_terms),
      .digits     (digits),
      .ops        (ops),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .last       (last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit refValid(input int n, input logic [4*MT-1:0] d);
      if (n < 1 || n > MT) return 1'b0;
      for (int i = 0; i < n; i++) begin
         if (d[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Expected stream: d0 op0 d1 op1 ... d(n-1) [ '=' ]
   task automatic pushModel(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
      logic [7:0] ch;
      logic       lf;
      for (int i = 0; i < n; i++) begin
         ch = 8'h30 + 8'(d[4*i +: 4]);
`ifdef EXPR_TX_TERMINATOR_EN
         lf = 1'b0;
`else
         lf = (i == n - 1);
`endif
         expq.push_back({lf, ch});
         if (i < n - 1) expq.push_back({1'b0, o[i] ? 8'h2A : 8'h2B});
      end
`ifdef EXPR_TX_TERMINATOR_EN
      expq.push_back({1'b1, 8'h3D});
`endif
   endtask

   // Sink readiness pattern: always, 1-0-0 repeating, or random
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       char_ready = 1'b1;
         1:       char_ready = (cyc % 3 == 0);
         default: char_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: checks presented characters, stall stability and the done pulse
   always @(negedge clk) begin
      logic [8:0] e;
      if (!clr_n) begin
         expq.delete();
         done_due   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(char_valid), 32'd1);
            checkOutput("stall_char", 32'(char_out), 32'(prev_char));
            checkOutput("stall_last", 32'(last), 32'(prev_last));
         end
         checkOutput("done_pulse", 32'(done), 32'(done_due));
         done_due = 1'b0;
         if (done) done_cyc = cyc;
         if (char_valid) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_char: got %0h expected none", char_out);
            end else begin
               e = expq[0];
               checkOutput("char", 32'(char_out), 32'(e[7:0]));
               checkOutput("last", 32'(last), 32'(e[8]));
               if (char_ready) begin
                  if (seen.size() == 0) first_cyc = cyc;
                  seen.push_back(char_out);
                  void'(expq.pop_front());
                  pops++;
                  if (expq.size() == 0) done_due = 1'b1;
               end
            end
         end
         prev_stall = char_valid && !char_ready;
         prev_char  = char_out;
         prev_last  = last;
      end
   end

   task automatic applyStimulus(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
      bit ok;
      ok = refValid(n, d);
      @(posedge clk);
      #1;
      n_terms = 4'(n);
      digits  = d;
      ops     = o;
      start   = 1'b1;
      if (ok) pushModel(n, d, o);
      @(posedge clk);
      #1;
      start   = 1'b0;
      n_terms = 4'($urandom);
      digits  = {$urandom, $urandom};
      ops     = (MT-1)'($urandom);
      #2;
      if (ok) begin
         checkOutput("err_on_ok", 32'(err), 32'd0);
         checkOutput("busy_on_ok", 32'(busy), 32'd1);
      end else begin
         checkOutput("err_on_bad", 32'(err), 32'd1);
         checkOutput("valid_on_bad", 32'(char_valid), 32'd0);
         checkOutput("busy_on_bad", 32'(busy), 32'd0);
         @(posedge clk);
         #2;
         checkOutput("err_one_cycle", 32'(err), 32'd0);
      end
   endtask

   task automatic waitIdle();
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!busy) begin
            idle = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("idle_reached", 32'(idle), 32'd1);
      checkOutput("model_drained", 32'(expq.size()), 32'd0);
   endtask

   task automatic checkSeen(input string name, input logic [7:0] e[$]);
      checkOutput({name, "_len"}, 32'(seen.size()), 32'(e.size()));
      for (int i = 0; i < e.size(); i++) begin
         if (i < seen.size()) checkOutput(name, 32'(seen[i]), 32'(e[i]));
      end
   endtask

   initial begin
      logic [7:0] lit371[$];
      int         base;
      int         n;
      logic [4*MT-1:0] d;

`ifdef EXPR_TX_TERMINATOR_EN
      lit371 = '{8'h33, 8'h2B, 8'h37, 8'h2A, 8'h31, 8'h3D};
`else
      lit371 = '{8'h33, 8'h2B, 8'h37, 8'h2A, 8'h31};
`endif

      // Reset values
      #2;
      checkOutput("rst_char", 32'(char_out), 32'h00);
      checkOutput("rst_valid", 32'(char_valid), 32'd0);
      checkOutput("rst_last", 32'(last), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      #10;
      clr_n = 1'b1;

      // {3,7,1} with '+','*' and a free-running sink
      ready_mode = 0;
      seen.delete();
      applyStimulus(3, 16'h0173, 3'b010);
      waitIdle();
      checkSeen("seq371", lit371);
      checkOutput("done_latency", 32'(done_cyc - first_cyc), 32'(lit371.size()));

      // Same request with the 1,0,0 backpressure pattern
      ready_mode = 1;
      seen.delete();
      applyStimulus(3, 16'h0173, 3'b010);
      waitIdle();
      checkSeen("seq371_bp", lit371);

      // Single term
      ready_mode = 0;
      seen.delete();
      applyStimulus(1, 16'hEEE5, 3'b111);
      waitIdle();
`ifdef EXPR_TX_TERMINATOR_EN
      checkSeen("single", '{8'h35, 8'h3D});
`else
      checkSeen("single", '{8'h35});
`endif

      // Rejected requests
      applyStimulus(2, 16'h00A0, 3'b000);
      applyStimulus(0, 16'h0123, 3'b000);
      applyStimulus(MT + 1, 16'h1234, 3'b000);

      // Reset after the second character has been accepted
      ready_mode = 0;
      base = pops;
      applyStimulus(3, 16'h0173, 3'b010);
      for (int k = 0; k < 50; k++) begin
         if (pops >= base + 2) break;
         @(negedge clk);
         #1;
      end
      checkOutput("reached_2nd_char", 32'(pops >= base + 2), 32'd1);
      @(posedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(char_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_char", 32'(char_out), 32'h00);
      checkOutput("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      clr_n = 1'b1;
      seen.delete();
      applyStimulus(3, 16'h0173, 3'b010);
      waitIdle();
      checkSeen("after_rst", lit371);

      // start while busy with different inputs must be ignored
      ready_mode = 1;
      seen.delete();
      applyStimulus(3, 16'h0173, 3'b010);
      @(posedge clk);
      #1;
      n_terms = 4'd2;
      digits  = 16'h0099;
      ops     = 3'b111;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      #2;
      checkOutput("busy_start_err", 32'(err), 32'd0);
      waitIdle();
      checkSeen("busy_start", lit371);

      // Randomized requests, mostly valid, with random sink behaviour
      for (int it = 0; it < 40; it++) begin
         ready_mode = $urandom_range(0, 2);
         n = $urandom_range(0, MT + 1);
         for (int i = 0; i < MT; i++) d[4*i +: 4] = 4'($urandom_range(0, 11));
         applyStimulus(n, d, (MT-1)'($urandom));
         waitIdle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
